// File: rtl/operand_loader.sv
// Assembles one ALU operation (A, B, opcode) from switches and a debounced button,
// presenting num1/num2/opcode atomically. Optional idle timeout: OPLOAD_TIMEOUT_EN.
module operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic       opcode,
  output logic       valid,
  output logic       commit,
  output logic [1:0] stage
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } state_e;

  logic          btn_meta_q, btn_sync_q;
  logic [3:0]    sw_meta_q, sw_sync_q;
  logic          db_level_q, db_level_d;
  logic          db_level_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;
  logic          armed_q, armed_d;
  state_e        state_q, state_d;
  logic [3:0]    a_shadow_q, a_shadow_d;
  logic [3:0]    b_shadow_q, b_shadow_d;
  logic [3:0]    num1_q, num1_d;
  logic [3:0]    num2_q, num2_d;
  logic          opcode_q, opcode_d;
  logic          valid_q, valid_d;
  logic          commit_q, commit_d;
  logic          press;

`ifdef OPLOAD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

  // Debounce: a new synced level must persist DEBOUNCE_CYCLES cycles to be accepted.
  always_comb begin
    db_level_d = db_level_q;
    cnt_d      = '0;
    if (btn_sync_q != db_level_q) begin
      if (cnt_q == CNT_LAST) begin
        db_level_d = ~db_level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Arming needs a full debounce period of low input, so a button held through
  // reset yields nothing until it is released and pressed again.
  always_comb begin
    armed_d   = armed_q;
    arm_cnt_d = '0;
    if (!armed_q && !btn_sync_q) begin
      if (arm_cnt_q == CNT_LAST) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + 1'b1;
      end
    end
  end

  assign press = db_level_q & ~db_level_dly_q & armed_q;

  always_comb begin
    state_d    = state_q;
    a_shadow_d = a_shadow_q;
    b_shadow_d = b_shadow_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    opcode_d   = opcode_q;
    valid_d    = valid_q;
    commit_d   = 1'b0;
`ifdef OPLOAD_TIMEOUT_EN
    timer_d    = '0;
`endif
    case (state_q)
      S_A: if (press) begin
        a_shadow_d = sw_sync_q;
        state_d    = S_B;
      end
      S_B: if (press) begin
        b_shadow_d = sw_sync_q;
        state_d    = S_OP;
      end
      S_OP: if (press) begin
        num1_d   = a_shadow_q;
        num2_d   = b_shadow_q;
        opcode_d = sw_sync_q[0];
        valid_d  = 1'b1;
        commit_d = 1'b1;
        state_d  = S_SHOW;
      end
      default: if (press) begin
        state_d = S_A;
      end
    endcase
`ifdef OPLOAD_TIMEOUT_EN
    // Abandon a stale partial entry; committed outputs are left untouched.
    if ((state_q == S_B || state_q == S_OP) && !press) begin
      if (timer_q == TIMER_LAST) begin
        state_d    = S_A;
        a_shadow_d = '0;
        b_shadow_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q     <= 1'b0;
      btn_sync_q     <= 1'b0;
      sw_meta_q      <= '0;
      sw_sync_q      <= '0;
      db_level_q     <= 1'b0;
      db_level_dly_q <= 1'b0;
      cnt_q          <= '0;
      arm_cnt_q      <= '0;
      armed_q        <= 1'b0;
      state_q        <= S_A;
      a_shadow_q     <= '0;
      b_shadow_q     <= '0;
      num1_q         <= '0;
      num2_q         <= '0;
      opcode_q       <= 1'b0;
      valid_q        <= 1'b0;
      commit_q       <= 1'b0;
`ifdef OPLOAD_TIMEOUT_EN
      timer_q        <= '0;
`endif
    end else begin
      btn_meta_q     <= btn;
      btn_sync_q     <= btn_meta_q;
      sw_meta_q      <= sw;
      sw_sync_q      <= sw_meta_q;
      db_level_q     <= db_level_d;
      db_level_dly_q <= db_level_q;
      cnt_q          <= cnt_d;
      arm_cnt_q      <= arm_cnt_d;
      armed_q        <= armed_d;
      state_q        <= state_d;
      a_shadow_q     <= a_shadow_d;
      b_shadow_q     <= b_shadow_d;
      num1_q         <= num1_d;
      num2_q         <= num2_d;
      opcode_q       <= opcode_d;
      valid_q        <= valid_d;
      commit_q       <= commit_d;
`ifdef OPLOAD_TIMEOUT_EN
      timer_q        <= timer_d;
`endif
    end
  end

  assign num1   = num1_q;
  assign num2   = num2_q;
  assign opcode = opcode_q;
  assign valid  = valid_q;
  assign commit = commit_q;
  assign stage  = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader; committed operations are checked through a
// scoreboard queue popped on each commit pulse.
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic [3:0] sw;
  logic [3:0] num1, num2;
  logic       opcode, valid, commit;
  logic [1:0] stage;

  int checks  = 0;
  int errors  = 0;
  int commits = 0;

  typedef struct packed {
    logic [3:0] n1;
    logic [3:0] n2;
    logic       op;
  } exp_t;
  exp_t sbq[$];

  operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .btn   (btn),
    .num1  (num1),
    .num2  (num2),
    .opcode(opcode),
    .valid (valid),
    .commit(commit),
    .stage (stage)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Button held 7 cycles (press acts on the 7th sampled-high edge), then 7 low.
  task automatic press(input logic [3:0] s);
    sw = s;
    btn = 1'b1;
    repeat (7) @(posedge clk);
    #1 btn = 1'b0;
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] n1, input logic [3:0] n2,
                           input logic op);
    check({tag, "_num1"}, 32'(num1), 32'(n1));
    check({tag, "_num2"}, 32'(num2), 32'(n2));
    check({tag, "_opcode"}, 32'(opcode), 32'(op));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && commit === 1'b1) begin
      exp_t e;
      commits++;
      if (sbq.size() == 0) begin
        check("commit_unexpected", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check_out("sb", e.n1, e.n2, e.op);
        check("sb_valid", 32'(valid), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    sw    = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 4'h0, 4'h0, 1'b0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_commit", 32'(commit), 32'd0);
    check("reset_stage", 32'(stage), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Test 1: 5 + 3, add
    press(4'h5);
    check("t1_stage_b", 32'(stage), 32'd1);
    press(4'h3);
    check("t1_stage_op", 32'(stage), 32'd2);
    sbq.push_back(exp_t'{n1: 4'h5, n2: 4'h3, op: 1'b0});
    press(4'h0);
    check("t1_stage_show", 32'(stage), 32'd3);
    check_out("t1", 4'h5, 4'h3, 1'b0);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_commits", 32'(commits), 32'd1);

    // Test 2: outputs must hold previous values during A and B entry
    press(4'h0);
    check("t2_stage_a", 32'(stage), 32'd0);
    press(4'hF);
    check_out("t2_after_a", 4'h5, 4'h3, 1'b0);
    press(4'hF);
    check_out("t2_after_b", 4'h5, 4'h3, 1'b0);
    check("t2_valid_hold", 32'(valid), 32'd1);
    sbq.push_back(exp_t'{n1: 4'hF, n2: 4'hF, op: 1'b1});
    press(4'h1);
    check_out("t2", 4'hF, 4'hF, 1'b1);
    check("t2_commits", 32'(commits), 32'd2);
    press(4'h0);
    check("t2_back_to_a", 32'(stage), 32'd0);

    // Test 3: glitch train rejected, then exact press latency
    sw = 4'h9;
    for (int i = 0; i < 30; i++) begin
      btn = ~btn;
      @(posedge clk);
      #1;
    end
    btn = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t3_glitch_stage", 32'(stage), 32'd0);
    check("t3_glitch_commits", 32'(commits), 32'd2);
    btn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    btn = 1'b0;
    check("t3_edge6_stage", 32'(stage), 32'd0);
    @(posedge clk);
    #1;
    check("t3_edge7_stage", 32'(stage), 32'd1);
    repeat (7) @(posedge clk);
    #1;
    press(4'h2);
    sbq.push_back(exp_t'{n1: 4'h9, n2: 4'h2, op: 1'b1});
    press(4'h1);
    check_out("t3", 4'h9, 4'h2, 1'b1);

    // Test 5: reset mid-entry clears outputs before the next edge
    press(4'h0);
    press(4'hA);
    press(4'hB);
    check("t5_stage_op", 32'(stage), 32'd2);
    rst_n = 1'b0;
    #1;
    check_out("t5", 4'h0, 4'h0, 1'b0);
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_commit", 32'(commit), 32'd0);
    check("t5_stage", 32'(stage), 32'd0);

    // Test 4: button held through reset release gives no press
    btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t4_held_stage", 32'(stage), 32'd0);
    btn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t4_release_stage", 32'(stage), 32'd0);
    press(4'h6);
    check("t4_repress_stage", 32'(stage), 32'd1);

    // Test 6: idle partial entry
    press(4'h4);
    sbq.push_back(exp_t'{n1: 4'h6, n2: 4'h4, op: 1'b0});
    press(4'h0);
    check_out("t6_commit", 4'h6, 4'h4, 1'b0);
    press(4'h0);
    press(4'h7);
    check("t6_stage_b", 32'(stage), 32'd1);
`ifdef OPLOAD_TIMEOUT_EN
    repeat (20) @(posedge clk);
    #1;
    check("t6_timeout_stage", 32'(stage), 32'd0);
    check_out("t6_timeout", 4'h6, 4'h4, 1'b0);
    check("t6_timeout_valid", 32'(valid), 32'd1);
    press(4'h8);
    press(4'h9);
    sbq.push_back(exp_t'{n1: 4'h8, n2: 4'h9, op: 1'b1});
    press(4'h1);
    check_out("t6_after", 4'h8, 4'h9, 1'b1);
    check("t6_commits", 32'(commits), 32'd5);
`else
    repeat (100) @(posedge clk);
    #1;
    check("t6_wait_stage", 32'(stage), 32'd1);
    check_out("t6_wait", 4'h6, 4'h4, 1'b0);
    check("t6_wait_valid", 32'(valid), 32'd1);
    check("t6_commits", 32'(commits), 32'd4);
`endif
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
